// File: rtl/hit_judge.sv
`default_nettype none
// ============================================================================
// Module      : hit_judge
// Description : Synchronises and debounces the player buttons, judges each
//               press against the latched target, emits one-cycle hit/miss/
//               ack pulses, keeps saturating score/miss counters and freezes
//               once the timer reports failure.
//               Optional macro HIT_JUDGE_MISS_LIMIT_EN ends the game when the
//               miss counter reaches MISS_LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module hit_judge #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCORE_W         = 16,
    parameter int MISS_LIMIT      = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [NUM_BTN-1:0] target,
    input  logic               target_valid,
    input  logic               game_fail_in,
    output logic               target_ack,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         miss_count,
    output logic               game_over
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_OVER    = 2'd3;

`ifdef HIT_JUDGE_MISS_LIMIT_EN
    localparam logic [7:0] MISS_LIMIT_C = 8'(MISS_LIMIT);
`else
    logic unused_miss_limit;
    assign unused_miss_limit = ^MISS_LIMIT;
`endif

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] db_q, db_d;
    logic [NUM_BTN-1:0] db_prev_q, db_prev_d;
    logic [NUM_BTN-1:0] target_q, target_d;
    logic [1:0]         state_q, state_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               ack_q, ack_d;
    logic               game_over_q, game_over_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         miss_count_q, miss_count_d;

    logic [NUM_BTN-1:0] pressed;
    logic               press_event;
    logic               press_match;

    // Per-button debounce: accept the synchronised level only after it has
    // disagreed with the debounced level for DEBOUNCE_CYCLES straight clocks.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             db_nxt;

        // Count consecutive disagreeing cycles; agreement clears the count
        always_comb begin
            cnt_d  = '0;
            db_nxt = db_q[i];
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q == CNT_LAST) begin
                    db_nxt = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Debounce counter register
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign db_d[i] = db_nxt;
    end

    // Rising edges of the debounced buttons form the press event
    assign pressed     = db_q & ~db_prev_q;
    assign press_event = |pressed;
    assign press_match = $onehot(pressed) && (pressed == target_q);

    // Input synchroniser chain and edge-detect history
    always_comb begin
        sync1_d   = btn;
        sync2_d   = sync1_q;
        db_prev_d = db_q;
    end

    // State and output register bank
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            db_prev_q    <= '0;
            target_q     <= '0;
            state_q      <= S_IDLE;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            ack_q        <= 1'b0;
            game_over_q  <= 1'b0;
            score_q      <= '0;
            miss_count_q <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            db_prev_q    <= db_prev_d;
            target_q     <= target_d;
            state_q      <= state_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            ack_q        <= ack_d;
            game_over_q  <= game_over_d;
            score_q      <= score_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Next-state logic; timer failure overrides everything
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (game_fail_in) begin
            state_d = S_OVER;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press_event) begin
                        state_d = S_RELEASE;
                    end else if (target_valid) begin
                        target_d = target;
                        state_d  = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (press_event) begin
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (db_q == '0) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_OVER;
            endcase
`ifdef HIT_JUDGE_MISS_LIMIT_EN
            if (miss_d && (miss_count_d == MISS_LIMIT_C)) begin
                state_d = S_OVER;
            end
`endif
        end
        game_over_d = (state_d == S_OVER);
    end

    // Pulse decisions and saturating counters
    always_comb begin
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        ack_d        = 1'b0;
        score_d      = score_q;
        miss_count_d = miss_count_q;
        if (!game_fail_in && press_event) begin
            case (state_q)
                S_IDLE: miss_d = 1'b1;
                S_ARMED: begin
                    ack_d = 1'b1;
                    if (press_match) begin
                        hit_d = 1'b1;
                    end else begin
                        miss_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (hit_d && (score_q != '1)) begin
            score_d = score_q + 1'b1;
        end
        if (miss_d && (miss_count_q != 8'hFF)) begin
            miss_count_d = miss_count_q + 8'd1;
        end
    end

    assign hit        = hit_q;
    assign miss       = miss_q;
    assign target_ack = ack_q;
    assign score      = score_q;
    assign miss_count = miss_count_q;
    assign game_over  = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_hit_judge.sv
`default_nettype none
// ============================================================================
// Module      : tb_hit_judge
// Description : Randomised self-checking bench for hit_judge with a
//               transaction-level reference model of the judging rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hit_judge;

    localparam int NB  = 4;
    localparam int DB  = 4;
    localparam int SW  = 4;
    localparam int LAT = DB + 3;  // negedges from stable press to visible pulse
`ifdef HIT_JUDGE_MISS_LIMIT_EN
    localparam int LIMIT = 2;
`else
    localparam int LIMIT = 5;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] target = '0;
    logic          target_valid = 1'b0;
    logic          game_fail_in = 1'b0;
    logic          target_ack, hit, miss, game_over;
    logic [SW-1:0] score;
    logic [7:0]    miss_count;

    hit_judge #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .SCORE_W(SW), .MISS_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset), .btn(btn), .target(target),
        .target_valid(target_valid), .game_fail_in(game_fail_in),
        .target_ack(target_ack), .hit(hit), .miss(miss), .score(score),
        .miss_count(miss_count), .game_over(game_over)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_hit, n_miss, n_ack, n_both, first_pulse;

    // reference model state
    int m_score = 0;
    int m_miss  = 0;
    bit m_over  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_mon();
        n_hit = 0; n_miss = 0; n_ack = 0; n_both = 0; first_pulse = -1;
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        if (hit) n_hit++;
        if (miss) n_miss++;
        if (target_ack) n_ack++;
        if (hit && miss) n_both++;
        if ((hit || miss) && first_pulse < 0) first_pulse = cyc;
    endtask

    task automatic check_counters();
        check("score", 32'(score), 32'(m_score));
        check("miss_count", 32'(miss_count), 32'(m_miss));
        check("game_over", 32'(game_over), 32'(m_over));
    endtask

    task automatic reset_dut();
        reset = 1'b1; btn = '0; target_valid = 1'b0; game_fail_in = 1'b0;
        step(); step();
        check("rst_hit", 32'(hit), 0);
        check("rst_miss", 32'(miss), 0);
        check("rst_ack", 32'(target_ack), 0);
        check("rst_score", 32'(score), 0);
        check("rst_miss_count", 32'(miss_count), 0);
        check("rst_game_over", 32'(game_over), 0);
        reset = 1'b0;
        m_score = 0; m_miss = 0; m_over = 0;
        step();
    endtask

    // One player action: optional target, optional bounce, optional rollover
    // press while held, then release.
    task automatic press_txn(input logic [NB-1:0] mask, input bit use_tgt,
                             input logic [NB-1:0] tgt, input bit bounce,
                             input bit extra, input bit drop_valid);
        int j0, r;
        bit e_hit, e_miss, e_ack;
        logic [NB-1:0] other;
        clear_mon();
        target = tgt;
        target_valid = use_tgt;
        step(); step();
        if (drop_valid) target_valid = 1'b0;
        if (bounce) begin
            for (int b = 0; b < 1 + int'($urandom_range(0, 1)); b++) begin
                btn = mask;
                r = $urandom_range(1, DB - 1);
                repeat (r) step();
                btn = '0;
                r = $urandom_range(1, DB - 1);
                repeat (r) step();
            end
        end
        btn = mask;
        j0 = cyc;
        repeat (LAT + 5) step();

        e_hit = 0; e_miss = 0; e_ack = 0;
        if (!m_over) begin
            if (!use_tgt) begin
                e_miss = 1;
            end else begin
                e_ack = 1;
                if (mask == tgt) e_hit = 1;
                else e_miss = 1;
            end
        end
        if (e_hit && m_score < (1 << SW) - 1) m_score++;
        if (e_miss && m_miss < 255) m_miss++;
`ifdef HIT_JUDGE_MISS_LIMIT_EN
        if (e_miss && m_miss == LIMIT) m_over = 1;
`endif
        check("hit_pulses", 32'(n_hit), 32'(e_hit));
        check("miss_pulses", 32'(n_miss), 32'(e_miss));
        check("ack_pulses", 32'(n_ack), 32'(e_ack));
        check("hit_and_miss", 32'(n_both), 0);
        if (e_hit || e_miss) check("latency", 32'(first_pulse - j0), 32'(LAT));
        check_counters();

        target_valid = 1'b0;
        if (extra) begin
            other = '0;
            for (int i = 0; i < NB; i++) if (!mask[i] && other == '0) other[i] = 1'b1;
            clear_mon();
            btn = mask | other;
            repeat (DB + 6) step();
            check("rollover_pulses", 32'(n_hit + n_miss + n_ack), 0);
        end
        clear_mon();
        btn = '0;
        repeat (DB + 6) step();
        check("release_pulses", 32'(n_hit + n_miss + n_ack), 0);
    endtask

    // Correct press with the timer failing on the very press-event cycle
    task automatic fail_txn();
        clear_mon();
        target = 4'b0100;
        target_valid = 1'b1;
        step(); step();
        btn = 4'b0100;
        repeat (LAT - 1) step();
        game_fail_in = 1'b1;
        repeat (6) step();
        m_over = 1;
        check("fail_hit", 32'(n_hit), 0);
        check("fail_ack", 32'(n_ack), 0);
        check("fail_miss", 32'(n_miss), 0);
        check_counters();
        btn = '0;
        target_valid = 1'b0;
        repeat (DB + 6) step();
    endtask

    function automatic logic [NB-1:0] rand_onehot();
        logic [NB-1:0] v = '0;
        v[$urandom_range(0, NB - 1)] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [NB-1:0] mask, tgt;
        reset_dut();

        // directed: bounced correct hit, clean hit, wrong + rollover,
        // premature, two-button chord
        press_txn(4'b0001, 1, 4'b0001, 1, 0, 0);
        press_txn(4'b0010, 1, 4'b0010, 0, 0, 0);
        press_txn(4'b0100, 1, 4'b0001, 0, 1, 0);
        press_txn(4'b0001, 0, 4'b0000, 0, 0, 0);
        press_txn(4'b0011, 1, 4'b0001, 0, 0, 0);

        // randomised traffic
        for (int t = 0; t < 60; t++) begin
            tgt = rand_onehot();
            case ($urandom_range(0, 5))
                0:       mask = rand_onehot() | rand_onehot();
                1, 2:    mask = tgt;
                default: mask = rand_onehot();
            endcase
            press_txn(mask, ($urandom_range(0, 4) != 0), tgt,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 2) == 0);
        end

`ifndef HIT_JUDGE_MISS_LIMIT_EN
        // drive both counters into saturation; pulses must continue
        for (int t = 0; t < 20; t++) begin
            tgt = rand_onehot();
            press_txn(tgt, 1, tgt, 0, 0, 0);
        end
        for (int t = 0; t < 260; t++) press_txn(rand_onehot(), 0, '0, 0, 0, 0);
`endif

        reset_dut();
        fail_txn();
        press_txn(4'b1000, 1, 4'b1000, 0, 0, 0);
        reset_dut();

`ifdef HIT_JUDGE_MISS_LIMIT_EN
        press_txn(4'b0010, 1, 4'b0010, 0, 0, 0);
        press_txn(4'b0100, 1, 4'b0001, 0, 0, 0);
        press_txn(4'b1000, 1, 4'b0001, 1, 0, 0);
        press_txn(4'b0001, 1, 4'b0001, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Input-side counterpart of the countdown timer. The timer consumes `miss` and produces `game_fail_out`; this block produces `miss` and consumes `game_fail_out`.
- Synchronises and debounces the raw player buttons, then compares each press against the target supplied by the pattern generator.
- Emits single-cycle `hit`/`miss` pulses, keeps score and miss counters, and freezes once the timer reports failure.
- Sits between the board buttons, the pattern generator and the timer.

Parameters:
- NUM_BTN, 4, number of player buttons.
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a level change (10 ms at 50 MHz).
- SCORE_W, 16, width of the score counter.
- MISS_LIMIT, 5, miss count that ends the game; used only when HIT_JUDGE_MISS_LIMIT_EN is defined.

Ports:
- clock  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- btn  input  NUM_BTN  raw, bouncy, asynchronous buttons; 1 = pressed.
- target  input  NUM_BTN  one-hot expected button; valid while target_valid = 1.
- target_valid  input  1  pattern generator holds target until target_ack.
- game_fail_in  input  1  driven by the timer's `game_fail_out`.
- target_ack  output  1  one-cycle pulse; current target consumed.
- hit  output  1  one-cycle pulse; correct press.
- miss  output  1  one-cycle pulse; wrong or premature press. Drives the timer's `miss`.
- score  output  SCORE_W  hit count, saturating.
- miss_count  output  8  miss count, saturating at 255.
- game_over  output  1  level; stays high until reset.

Behaviour:
- Reset (asynchronous, active-high) clears all outputs, counters, synchronisers and debounced levels to 0. State = IDLE.
- Per button:
  - 2-flop synchroniser.
  - Debounce counter: the debounced level db[i] takes the synchronised value once that value has differed from db[i] for DEBOUNCE_CYCLES consecutive clocks. Any cycle where they agree clears the counter.
- Press event: one clock after any rising edge of db. `pressed` = one-hot db rising-edge vector. More than one bit set in the same cycle counts as a wrong press.
- All outputs are registered. hit, miss and target_ack assert the clock after the press event, for exactly 1 cycle.
- hit and miss are never high together.
- States:
  - IDLE:
    - target_valid=1 → latch target → ARMED.
    - Press event → miss=1 (premature), miss_count++ → RELEASE.
  - ARMED, on press event:
    - pressed == latched target → hit=1, target_ack=1, score++.
    - Otherwise → miss=1, target_ack=1, miss_count++.
    - In both cases → RELEASE.
  - RELEASE:
    - Wait until all db bits are 0 → IDLE.
    - Press events here are ignored (chording/rollover).
  - OVER:
    - All pulses held at 0; counters frozen; game_over=1.
    - Exit only via reset.
- game_fail_in=1 in any state → OVER on the next clock.
- If game_fail_in and a press event coincide, game_fail_in wins: no hit, miss or ack.
- target_valid dropping while in ARMED has no effect; the latched target is used.
- score saturates at 2^SCORE_W−1; miss_count saturates at 255. hit and miss still pulse at saturation.
- A reset mid-debounce discards the pending edge.

Optional Feature:
- Macro HIT_JUDGE_MISS_LIMIT_EN.
  - Defined: when miss_count reaches MISS_LIMIT (the increment that makes it equal), the next state is OVER. The miss pulse for that press is still emitted.
  - Undefined: only game_fail_in ends the game. The MISS_LIMIT parameter is unused.

Test Plan:
- Debounce: DEBOUNCE_CYCLES=4, btn[0] bounces 1-0-1 at 2-cycle spacing then holds 1 → exactly one press event. Before that, no db change while the glitches stay shorter than 4 cycles.
- Correct hit: target=4'b0010 valid, clean press of btn[1] → hit=1 and target_ack=1 for 1 cycle, score 0→1, miss=0.
- Wrong press: target=4'b0001, press btn[2] → miss=1 and target_ack=1 for 1 cycle, miss_count=1. A second press before release produces no pulse.
- Premature press and multi-press: press with target_valid=0 → miss pulse, no ack. Pressing btn[0] and btn[1] on the same cycle with target=4'b0001 → miss.
- Fail priority: game_fail_in=1 on the same cycle as a correct press event → no hit or ack, game_over=1 next cycle. Later presses → nothing. Reset → all outputs 0.
- HIT_JUDGE_MISS_LIMIT_EN, MISS_LIMIT=2: two wrong presses → second miss pulses, then game_over=1. Score is held.
